// File: rtl/servo_pkg.sv
// Shared constants, channel state type and width clamp for the servo PWM scheduler.
// The watchdog (SERVO_WDOG_EN) uses WDOG_FRAMES / WDOG_W from here.
package servo_pkg;

  localparam int PRESCALE_DEF   = 40;
  localparam int FRAME_US_DEF   = 20000;
  localparam int MIN_US_DEF     = 1000;
  localparam int MAX_US_DEF     = 2000;
  localparam int NEUTRAL_US_DEF = 1500;
  localparam int WDOG_FRAMES    = 25;
  localparam int CMD_W          = 11;
  localparam int WDOG_W         = $clog2(WDOG_FRAMES + 1);

  typedef logic [CMD_W-1:0] width_t;

  typedef enum logic [1:0] {
    NEUTRAL = 2'd0,
    RUN     = 2'd1,
    TRIPPED = 2'd2
  } chan_state_t;

  function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
    width_t r;
    r = w;
    if (w < lo) begin
      r = lo;
    end else if (w > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_chan.sv
// One servo channel: pending/active width registers, channel state machine, compare.
// Command watchdog and TRIPPED state exist only when SERVO_WDOG_EN is defined.
module servo_pwm_chan
  import servo_pkg::*;
#(
  parameter int FRAME_W    = 15,
  parameter int MIN_US     = MIN_US_DEF,
  parameter int MAX_US     = MAX_US_DEF,
  parameter int NEUTRAL_US = NEUTRAL_US_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               boundary,
  input  logic               cmd_acc,
  input  logic [CMD_W-1:0]   cmd_width,
  input  logic [FRAME_W-1:0] frame_cnt,
  output logic               pending_full,
  output logic               servo,
  output logic               wdog_trip
);

  localparam width_t MIN_W     = width_t'(MIN_US);
  localparam width_t MAX_W     = width_t'(MAX_US);
  localparam width_t NEUTRAL_W = width_t'(NEUTRAL_US);

  chan_state_t state_q, state_d;
  width_t      pending_q, pending_d;
  width_t      active_q, active_d;
  logic        pending_full_q, pending_full_d;
  logic        servo_q, servo_d;
  logic        latch;
  logic        wdog_expire;

  // A boundary consumes whatever was pending before this cycle's accept.
  assign latch = boundary && pending_full_q;

`ifdef SERVO_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

  assign wdog_expire = boundary && !pending_full_q && (state_q == RUN) &&
                       (wdog_cnt_q == WDOG_W'(WDOG_FRAMES - 1));

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (latch || (state_q != RUN)) begin
      wdog_cnt_d = '0;
    end else if (boundary) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NEUTRAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NEUTRAL: if (latch)       state_d = RUN;
      RUN:     if (wdog_expire) state_d = TRIPPED;
      TRIPPED: if (latch)       state_d = RUN;
      default:                  state_d = NEUTRAL;
    endcase
  end

  always_comb begin
    servo_d   = enable && (32'(frame_cnt) < 32'(active_q));
    wdog_trip = (state_q == TRIPPED);
  end

  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    if (latch) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end else if (wdog_expire) begin
      active_d = NEUTRAL_W;
    end
    if (cmd_acc) begin
      pending_d      = clamp_width(cmd_width, MIN_W, MAX_W);
      pending_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      active_q       <= NEUTRAL_W;
      servo_q        <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      active_q       <= active_d;
      servo_q        <= servo_d;
    end
  end

  assign pending_full = pending_full_q;
  assign servo        = servo_q;

endmodule

// File: rtl/servo_pwm_sched.sv
// Two-channel servo PWM scheduler: shared µs/frame timebase plus two double-buffered channels.
// Define SERVO_WDOG_EN to enable the per-channel command watchdog.
module servo_pwm_sched
  import servo_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int FRAME_US   = FRAME_US_DEF,
  parameter int MIN_US     = MIN_US_DEF,
  parameter int MAX_US     = MAX_US_DEF,
  parameter int NEUTRAL_US = NEUTRAL_US_DEF
) (
  input  logic             FAB_CLK,
  input  logic             MSS_RESET_N,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_chan,
  input  logic [CMD_W-1:0] cmd_width,
  output logic             SERVO_0,
  output logic             SERVO_1,
  output logic             frame_start,
  output logic [1:0]       wdog_trip
);

  localparam int TICK_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FRAME_W = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               frame_start_q, frame_start_d;
  logic               tick;
  logic               boundary;
  logic [1:0]         pending_full;
  logic [1:0]         servo;
  logic [1:0]         cmd_acc;

  assign tick     = enable && (tick_cnt_q == TICK_W'(PRESCALE - 1));
  assign boundary = tick && (frame_cnt_q == FRAME_W'(FRAME_US - 1));

  // Disabled timebase sits at 0 so pulses restart cleanly at frame_cnt 0.
  always_comb begin
    tick_cnt_d    = tick_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = boundary;
    if (!enable) begin
      tick_cnt_d  = '0;
      frame_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d  = '0;
      frame_cnt_d = boundary ? '0 : frame_cnt_q + FRAME_W'(1);
    end else begin
      tick_cnt_d  = tick_cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      tick_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cmd_ready = !pending_full[cmd_chan];

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign cmd_acc[gi] = cmd_valid && cmd_ready && (cmd_chan == 1'(gi));

    servo_pwm_chan #(
      .FRAME_W    (FRAME_W),
      .MIN_US     (MIN_US),
      .MAX_US     (MAX_US),
      .NEUTRAL_US (NEUTRAL_US)
    ) u_chan (
      .clk          (FAB_CLK),
      .rst_n        (MSS_RESET_N),
      .enable       (enable),
      .boundary     (boundary),
      .cmd_acc      (cmd_acc[gi]),
      .cmd_width    (cmd_width),
      .frame_cnt    (frame_cnt_q),
      .pending_full (pending_full[gi]),
      .servo        (servo[gi]),
      .wdog_trip    (wdog_trip[gi])
    );
  end

  assign SERVO_0     = servo[0];
  assign SERVO_1     = servo[1];
  assign frame_start = frame_start_q;

endmodule
